// File: rtl/fnd_pkg.sv
// Shared constants and helpers for the multiplexed 7-segment (FND) scan controller.
// Segment vectors are active-high and ordered {g,f,e,d,c,b,a}.
package fnd_pkg;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [3:0] CODE_DASH  = 4'hA;
  localparam logic [3:0] CODE_BLANK = 4'hF;

  typedef enum logic {
    PhaseOff = 1'b0,
    PhaseOn  = 1'b1
  } blink_phase_e;

  // Converts an active-high {dp, seg} byte to the board's pin polarity.
  function automatic logic [7:0] apply_polarity(input logic [7:0] val, input logic active_low);
    return active_low ? ~val : val;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational 4-bit code to 7-segment decoder.
//   code_i : digit code (0-9 numerals, A dash, B-F blank)
//   seg_o  : active-high segments {g,f,e,d,c,b,a}
module seg7_decode (
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);
  import fnd_pkg::*;

  always_comb begin
    seg_o = SEG_BLANK;
    case (code_i)
      4'h0:      seg_o = SEG_0;
      4'h1:      seg_o = SEG_1;
      4'h2:      seg_o = SEG_2;
      4'h3:      seg_o = SEG_3;
      4'h4:      seg_o = SEG_4;
      4'h5:      seg_o = SEG_5;
      4'h6:      seg_o = SEG_6;
      4'h7:      seg_o = SEG_7;
      4'h8:      seg_o = SEG_8;
      4'h9:      seg_o = SEG_9;
      CODE_DASH: seg_o = SEG_DASH;
      default:   seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Parametrised multiplexed 7-segment display scan controller.
//   clk, rst            : clock, asynchronous active-high reset
//   frame_bcd/frame_dp  : packed digit codes and dp requests (digit 0 rightmost)
//   blink_mask/lz_blank : per-digit blink enables, leading-zero blanking enable
//   load / load_ack     : frame update strobe, pulse when the frame goes live
//   frame_start         : pulse when the scan re-enters digit 0
//   an/seg/dp           : registered pin drives, polarity set by ACTIVE_LOW
// Frames are double-buffered: a load lands in a pending buffer and is copied to
// the displayed shadow buffer only on the wrap from the last digit to digit 0.
module fnd_scan_ctrl #(
  parameter int unsigned N_DIGITS     = 4,
  parameter int unsigned SCAN_DIV     = 100000,
  parameter int unsigned BLINK_FRAMES = 60,
  parameter int unsigned ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*N_DIGITS-1:0]   frame_bcd,
  input  logic [N_DIGITS-1:0]     frame_dp,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    lz_blank,
  input  logic                    load,
  output logic                    load_ack,
  output logic                    frame_start,
  output logic [N_DIGITS-1:0]     an,
  output logic [6:0]              seg,
  output logic                    dp
);
  import fnd_pkg::*;

  localparam int unsigned SelW   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int unsigned PresW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned BlinkW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic                 ActLow    = (ACTIVE_LOW != 0);
  localparam logic [SelW-1:0]      SelLast   = SelW'(N_DIGITS - 1);
  localparam logic [PresW-1:0]     PresLast  = PresW'(SCAN_DIV - 1);
  localparam logic [BlinkW-1:0]    BlinkLast = BlinkW'(BLINK_FRAMES - 1);
  localparam logic [N_DIGITS-1:0]  AnOff     = ActLow ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]           SegOff    = ActLow ? 7'h7F : 7'h00;
  localparam logic                 DpOff     = ActLow;

  // Scan timing state
  logic [PresW-1:0]  presc_q, presc_d;
  logic [SelW-1:0]   sel_q, sel_d;
  logic [BlinkW-1:0] blink_cnt_q, blink_cnt_d;
  blink_phase_e      phase_q, phase_d;

  // Pending (written by load) and shadow (displayed) frame buffers
  logic                  pend_valid_q, pend_valid_d;
  logic [4*N_DIGITS-1:0] pend_bcd_q, pend_bcd_d;
  logic [N_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [N_DIGITS-1:0]   pend_blink_q, pend_blink_d;
  logic                  pend_lz_q, pend_lz_d;
  logic [4*N_DIGITS-1:0] shd_bcd_q, shd_bcd_d;
  logic [N_DIGITS-1:0]   shd_dp_q, shd_dp_d;
  logic [N_DIGITS-1:0]   shd_blink_q, shd_blink_d;
  logic                  shd_lz_q, shd_lz_d;

  // Registered outputs
  logic [N_DIGITS-1:0] an_q, an_d;
  logic [6:0]          seg_q, seg_d;
  logic                dp_q, dp_d;
  logic                load_ack_q, load_ack_d;
  logic                frame_start_q, frame_start_d;

  // Combinational helpers
  logic                tick, wrap;
  logic                lead;
  logic [N_DIGITS-1:0] lz_mask;
  logic [3:0]          cur_code, dec_code;
  logic [6:0]          dec_seg;
  logic                blink_blank, digit_blank, dp_raw;
  logic [N_DIGITS-1:0] an_raw;
  logic [7:0]          segdp_pin;

  always_comb begin
    tick = (presc_q == PresLast);
    wrap = tick && (sel_q == SelLast);
  end

  // Prescaler, digit select and blink phase
  always_comb begin
    presc_d     = tick ? '0 : presc_q + PresW'(1);
    sel_d       = sel_q;
    blink_cnt_d = blink_cnt_q;
    phase_d     = phase_q;
    if (tick) begin
      sel_d = wrap ? '0 : sel_q + SelW'(1);
    end
    if (wrap) begin
      if (blink_cnt_q == BlinkLast) begin
        blink_cnt_d = '0;
        phase_d     = (phase_q == PhaseOn) ? PhaseOff : PhaseOn;
      end else begin
        blink_cnt_d = blink_cnt_q + BlinkW'(1);
      end
    end
  end

  // Load handshake: last load wins; a load coinciding with the wrap bypasses
  // the pending buffer straight into the shadow.
  always_comb begin
    pend_valid_d  = pend_valid_q;
    pend_bcd_d    = pend_bcd_q;
    pend_dp_d     = pend_dp_q;
    pend_blink_d  = pend_blink_q;
    pend_lz_d     = pend_lz_q;
    shd_bcd_d     = shd_bcd_q;
    shd_dp_d      = shd_dp_q;
    shd_blink_d   = shd_blink_q;
    shd_lz_d      = shd_lz_q;
    load_ack_d    = 1'b0;
    frame_start_d = wrap;

    if (load) begin
      pend_valid_d = 1'b1;
      pend_bcd_d   = frame_bcd;
      pend_dp_d    = frame_dp;
      pend_blink_d = blink_mask;
      pend_lz_d    = lz_blank;
    end

    if (wrap) begin
      pend_valid_d = 1'b0;
      if (load) begin
        shd_bcd_d   = frame_bcd;
        shd_dp_d    = frame_dp;
        shd_blink_d = blink_mask;
        shd_lz_d    = lz_blank;
        load_ack_d  = 1'b1;
      end else if (pend_valid_q) begin
        shd_bcd_d   = pend_bcd_q;
        shd_dp_d    = pend_dp_q;
        shd_blink_d = pend_blink_q;
        shd_lz_d    = pend_lz_q;
        load_ack_d  = 1'b1;
      end
    end
  end

  // Leading-zero mask: walk down from the top digit while codes stay zero.
  // Digit 0 is excluded so an all-zero frame still shows a single '0'.
  always_comb begin
    lead    = 1'b1;
    lz_mask = '0;
    for (int i = int'(N_DIGITS) - 1; i >= 1; i--) begin
      lead       = lead && (shd_bcd_q[4*i +: 4] == 4'h0);
      lz_mask[i] = shd_lz_q && lead;
    end
  end

  // Digit content for the currently selected position
  always_comb begin
    cur_code    = shd_bcd_q[sel_q*4 +: 4];
    blink_blank = shd_blink_q[sel_q] && (phase_q == PhaseOff);
    digit_blank = blink_blank || lz_mask[sel_q];
    dec_code    = digit_blank ? CODE_BLANK : cur_code;
    dp_raw      = shd_dp_q[sel_q] && !blink_blank;
  end

  seg7_decode u_seg7_decode (
    .code_i (dec_code),
    .seg_o  (dec_seg)
  );

  // Anodes are dark for the register update that coincides with a select
  // change so the old segment pattern never ghosts onto the next digit.
  always_comb begin
    an_raw    = tick ? '0 : ({{(N_DIGITS - 1){1'b0}}, 1'b1} << sel_q);
    an_d      = an_raw ^ {N_DIGITS{ActLow}};
    segdp_pin = apply_polarity({dp_raw, dec_seg}, ActLow);
    seg_d     = segdp_pin[6:0];
    dp_d      = segdp_pin[7];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q       <= '0;
      sel_q         <= '0;
      blink_cnt_q   <= '0;
      phase_q       <= PhaseOn;
      pend_valid_q  <= 1'b0;
      pend_bcd_q    <= '1;
      pend_dp_q     <= '0;
      pend_blink_q  <= '0;
      pend_lz_q     <= 1'b0;
      shd_bcd_q     <= '1;
      shd_dp_q      <= '0;
      shd_blink_q   <= '0;
      shd_lz_q      <= 1'b0;
      an_q          <= AnOff;
      seg_q         <= SegOff;
      dp_q          <= DpOff;
      load_ack_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      sel_q         <= sel_d;
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      pend_valid_q  <= pend_valid_d;
      pend_bcd_q    <= pend_bcd_d;
      pend_dp_q     <= pend_dp_d;
      pend_blink_q  <= pend_blink_d;
      pend_lz_q     <= pend_lz_d;
      shd_bcd_q     <= shd_bcd_d;
      shd_dp_q      <= shd_dp_d;
      shd_blink_q   <= shd_blink_d;
      shd_lz_q      <= shd_lz_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      load_ack_q    <= load_ack_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign an          = an_q;
  assign seg         = seg_q;
  assign dp          = dp_q;
  assign load_ack    = load_ack_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_fnd_scan_ctrl.sv
// Directed bench for fnd_scan_ctrl (4 digits, SCAN_DIV=4, BLINK_FRAMES=2, active-low).
// Frame timeline relative to the cycle frame_start is seen (offset 0):
// anodes dark at offsets 0,4,8,12; digit i is lit at offsets 4i+1..4i+3.
module tb_fnd_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] frame_bcd = '0;
  logic [3:0]  frame_dp = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_blank = 1'b0;
  logic        load = 1'b0;
  logic        load_ack;
  logic        frame_start;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  int n_cmp = 0;
  int n_err = 0;
  int frames = 0;
  int ack_cnt = 0;
  int ack0 = 0;

  always #5 clk = ~clk;

  always @(negedge clk) if (load_ack === 1'b1) ack_cnt++;

  fnd_scan_ctrl #(
    .N_DIGITS     (4),
    .SCAN_DIV     (4),
    .BLINK_FRAMES (2),
    .ACTIVE_LOW   (1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_bcd   (frame_bcd),
    .frame_dp    (frame_dp),
    .blink_mask  (blink_mask),
    .lz_blank    (lz_blank),
    .load        (load),
    .load_ack    (load_ack),
    .frame_start (frame_start),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  // Advances to the next frame_start pulse, bounded.
  task automatic wait_fs();
    int n;
    n = 0;
    cyc();
    while (frame_start !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk("frame_start seen", {31'd0, frame_start}, 32'd1);
    chk("ghost an at wrap", {28'd0, an}, 32'hF);
    frames++;
  endtask

  task automatic do_load(input logic [15:0] b, input logic [3:0] d, input logic [3:0] m,
                         input logic z);
    frame_bcd  = b;
    frame_dp   = d;
    blink_mask = m;
    lz_blank   = z;
    load       = 1'b1;
    cyc();
    load       = 1'b0;
  endtask

  // Called at offset 0; checks each digit mid-slot. segs = {d3,d2,d1,d0}, dps = pin values.
  task automatic do_frame(input string tag, input logic [27:0] segs, input logic [3:0] dps);
    logic [3:0] an_exp;
    for (int i = 0; i < 4; i++) begin
      cycles((i == 0) ? 2 : 4);
      an_exp = ~(4'b0001 << i);
      chk($sformatf("%s an d%0d", tag, i), {28'd0, an}, {28'd0, an_exp});
      chk($sformatf("%s seg d%0d", tag, i), {25'd0, seg}, {25'd0, segs[7*i +: 7]});
      chk($sformatf("%s dp d%0d", tag, i), {31'd0, dp}, {31'd0, dps[i]});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // 1. Reset and first frame
    #2 rst = 1'b1;
    cycles(3);
    chk("rst an", {28'd0, an}, 32'hF);
    chk("rst seg", {25'd0, seg}, 32'h7F);
    chk("rst dp", {31'd0, dp}, 32'd1);
    chk("rst load_ack", {31'd0, load_ack}, 32'd0);
    chk("rst frame_start", {31'd0, frame_start}, 32'd0);
    rst = 1'b0;
    cycles(15);
    chk("fs not yet at 15", {31'd0, frame_start}, 32'd0);
    cyc();
    chk("fs at 16", {31'd0, frame_start}, 32'd1);
    chk("no ack first frame", {31'd0, load_ack}, 32'd0);
    frames = 1;
    do_frame("blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);

    // 2. Single load
    wait_fs();
    chk("idle no ack", {31'd0, load_ack}, 32'd0);
    do_load(16'h1234, 4'b0100, 4'b0000, 1'b0);
    wait_fs();
    chk("ack 1234", {31'd0, load_ack}, 32'd1);
    cyc();
    chk("ack one cycle", {31'd0, load_ack}, 32'd0);
    cycles(15);
    chk("fs 1234 frame", {31'd0, frame_start}, 32'd1);
    frames++;
    do_frame("1234", {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1011);

    // 3. Two loads in one frame: last wins, single ack
    wait_fs();
    ack0 = ack_cnt;
    do_load(16'h1111, 4'b0000, 4'b0000, 1'b0);
    do_load(16'h2222, 4'b0000, 4'b0000, 1'b0);
    wait_fs();
    chk("ack 2222", {31'd0, load_ack}, 32'd1);
    do_frame("2222", {7'h24, 7'h24, 7'h24, 7'h24}, 4'b1111);
    chk("single ack", ack_cnt, ack0 + 1);

    // 4. Leading-zero blanking, dp kept on a blanked digit
    wait_fs();
    do_load(16'h0070, 4'b1000, 4'b0000, 1'b1);
    wait_fs();
    chk("ack 0070", {31'd0, load_ack}, 32'd1);
    do_frame("lz 0070", {7'h7F, 7'h7F, 7'h78, 7'h40}, 4'b0111);
    wait_fs();
    do_load(16'h0000, 4'b0000, 4'b0000, 1'b1);
    wait_fs();
    do_frame("lz 0000", {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111);

    // 5. Blink on digits 0 and 1; phase flips every second wrap since reset
    wait_fs();
    do_load(16'h1259, 4'b0001, 4'b0011, 1'b0);
    for (int f = 0; f < 4; f++) begin
      wait_fs();
      if (f == 0) chk("ack blink", {31'd0, load_ack}, 32'd1);
      if (((frames / 2) % 2) == 0) begin
        do_frame("blink on", {7'h79, 7'h24, 7'h12, 7'h10}, 4'b1110);
      end else begin
        do_frame("blink off", {7'h79, 7'h24, 7'h7F, 7'h7F}, 4'b1111);
      end
    end

    // 6. Reset mid-scan with a load pending
    wait_fs();
    cycles(5);
    do_load(16'h8888, 4'b1111, 4'b0000, 1'b0);
    cycles(4);
    chk("pre-rst an lit", {28'd0, an}, 32'hB);
    ack0 = ack_cnt;
    rst = 1'b1;
    #1;
    chk("async rst an", {28'd0, an}, 32'hF);
    chk("async rst seg", {25'd0, seg}, 32'h7F);
    chk("async rst dp", {31'd0, dp}, 32'd1);
    @(negedge clk);
    cycles(3);
    rst = 1'b0;
    frames = 0;
    cycles(15);
    chk("post-rst fs at 15", {31'd0, frame_start}, 32'd0);
    cyc();
    chk("post-rst fs at 16", {31'd0, frame_start}, 32'd1);
    chk("post-rst no ack", {31'd0, load_ack}, 32'd0);
    frames = 1;
    do_frame("post-rst blank", {7'h7F, 7'h7F, 7'h7F, 7'h7F}, 4'b1111);
    wait_fs();
    chk("post-rst still no ack", {31'd0, load_ack}, 32'd0);
    chk("post-rst ack count", ack_cnt, ack0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
